logic_unit_arbiter: RTL and testbench

//   Shares one 2-bit bitwise logic unit (out1 = {a|b, a&b}, xor = a^b) between NUM_REQ requesters.

---
 rtl/logic_unit_arbiter.sv | 97 +++++++++
 tb/tb_logic_unit_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin share of a 2-bit logic unit {a|b, a&b}, a^b across NUM_REQ requesters; 1-cycle latency.
// A full output stage with rsp_ready low withholds every req_ready; optional LOGIC_ARB_STATS_EN adds xfer_cnt.
module logic_unit_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [1:0]           rsp_out1,
  output logic                 rsp_xor
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [15:0]          xfer_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_idx;
  logic            win_vld;
  logic [ID_W-1:0] cand_idx;
  int              cand;
  logic            can_accept;
  logic            accept;
  logic [1:0]      win_ops;

  // Scan from rr_ptr with an explicit wrap so a non-power-of-2 count never indexes past NUM_REQ-1.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!win_vld && req_valid[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign rsp_valid  = (state == FULL);
  // Gated by rst_n so no grant is offered while reset is held.
  assign can_accept = rst_n && (!rsp_valid || rsp_ready);
  assign accept     = win_vld && can_accept;
  assign win_ops    = req_data[{win_idx, 1'b0} +: 2];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      rsp_id   <= '0;
      rsp_out1 <= '0;
      rsp_xor  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_id   <= win_idx;
        rsp_out1 <= {win_ops[0] | win_ops[1], win_ops[0] & win_ops[1]};
        rsp_xor  <= win_ops[0] ^ win_ops[1];
        rr_ptr   <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      xfer_cnt <= '0;
    else if (accept) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: vector table, directed multi-cycle sequences, random run against a reference model.
module tb_logic_unit_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [7:0] req_data;
  logic [3:0] req_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_id;
  logic [1:0] rsp_out1;
  logic       rsp_xor;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0] xfer_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out1  (rsp_out1),
    .rsp_xor   (rsp_xor)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  typedef struct {
    logic [3:0] v;
    logic [7:0] d;
    logic       rdy;
    logic [3:0] exp_rdy;
    logic       exp_vld;
    logic [1:0] exp_id;
    logic [1:0] exp_out1;
    logic       exp_xor;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [1:0] ref_out1(input logic [7:0] d, input int id);
    logic a, b;
    a = d[2*id];
    b = d[2*id+1];
    return {a | b, a & b};
  endfunction

  function automatic logic ref_xor(input logic [7:0] d, input int id);
    return d[2*id] ^ d[2*id+1];
  endfunction

  function automatic int ref_winner(input logic [3:0] v, input int rr);
    for (int k = 0; k < 4; k++)
      if (v[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  vec_t tv[7];

  initial begin
    logic [7:0] d_all;
    logic [1:0] hold_out1;
    logic       hold_xor;

    tv[0] = '{4'b0100, 8'b00_11_00_00, 1'b1, 4'b0100, 1'b1, 2'd2, 2'b11, 1'b0};
    tv[1] = '{4'b1001, 8'b01_00_00_10, 1'b1, 4'b1000, 1'b1, 2'd3, 2'b10, 1'b1};
    tv[2] = '{4'b0001, 8'b01_00_00_10, 1'b1, 4'b0001, 1'b1, 2'd0, 2'b10, 1'b1};
    tv[3] = '{4'b0000, 8'b00_00_00_00, 1'b0, 4'b0000, 1'b1, 2'd0, 2'b10, 1'b1};
    tv[4] = '{4'b0010, 8'b00_00_00_00, 1'b0, 4'b0000, 1'b1, 2'd0, 2'b10, 1'b1};
    tv[5] = '{4'b0010, 8'b00_00_00_00, 1'b1, 4'b0010, 1'b1, 2'd1, 2'b00, 1'b0};
    tv[6] = '{4'b0000, 8'b00_00_00_00, 1'b1, 4'b0000, 1'b0, 2'd0, 2'b00, 1'b0};

    // Reset state, with every requester asking.
    do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_out1", rsp_out1, 0);
    chk("rst_rsp_xor", rsp_xor, 0);
    chk("rst_req_ready", req_ready, 0);
    do_reset();

    // Table vectors: single request, wrap-around grant, backpressure hold, drain.
    for (int i = 0; i < 7; i++) begin
      req_valid = tv[i].v;
      req_data  = tv[i].d;
      rsp_ready = tv[i].rdy;
      #1;
      chk($sformatf("tbl%0d_req_ready", i), req_ready, tv[i].exp_rdy);
      tick();
      chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tv[i].exp_vld);
      if (tv[i].exp_vld) begin
        chk($sformatf("tbl%0d_rsp_id", i), rsp_id, tv[i].exp_id);
        chk($sformatf("tbl%0d_rsp_out1", i), rsp_out1, tv[i].exp_out1);
        chk($sformatf("tbl%0d_rsp_xor", i), rsp_xor, tv[i].exp_xor);
      end
    end

    // All four continuously valid from reset: ids rotate 0,1,2,3 one per cycle.
    do_reset();
    d_all     = 8'($urandom);
    req_valid = 4'b1111;
    req_data  = d_all;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rot_req_ready", req_ready, 4'b0001 << (i % 4));
      tick();
      chk("rot_rsp_valid", rsp_valid, 1);
      chk("rot_rsp_id", rsp_id, i % 4);
      chk("rot_rsp_out1", rsp_out1, ref_out1(d_all, i % 4));
      chk("rot_rsp_xor", rsp_xor, ref_xor(d_all, i % 4));
    end

    // Stall five cycles: result frozen, no grants, priority not rotated.
    hold_out1 = ref_out1(d_all, 3);
    hold_xor  = ref_xor(d_all, 3);
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_req_ready", req_ready, 0);
      tick();
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_id", rsp_id, 3);
      chk("stall_rsp_out1", rsp_out1, hold_out1);
      chk("stall_rsp_xor", rsp_xor, hold_xor);
    end
    rsp_ready = 1'b1;
    #1;
    chk("unstall_req_ready", req_ready, 4'b0001);
    tick();
    chk("unstall_rsp_valid", rsp_valid, 1);
    chk("unstall_rsp_id", rsp_id, 0);

    // Async reset while full drops the result at once; priority restarts at 0.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_rsp_id", rsp_id, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_arst_req_ready", req_ready, 4'b0001);
    tick();
    chk("post_arst_rsp_id", rsp_id, 0);

    // Randomized traffic against the reference model.
    begin
      logic [3:0] pv;
      logic [1:0] pd[4];
      logic       m_vld;
      int         m_id;
      logic [1:0] m_out1;
      logic       m_xor;
      int         m_rr;
      logic [7:0] dv;
      logic       can;
      int         w;
      logic [3:0] exp_rdy;

      do_reset();
      pv     = '0;
      m_vld  = 1'b0;
      m_id   = 0;
      m_out1 = '0;
      m_xor  = 1'b0;
      m_rr   = 0;
      for (int i = 0; i < 4; i++) pd[i] = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        for (int i = 0; i < 4; i++)
          if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
            pv[i] = 1'b1;
            pd[i] = 2'($urandom);
          end
        dv        = {pd[3], pd[2], pd[1], pd[0]};
        req_valid = pv;
        req_data  = dv;
        rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
        can     = !m_vld || rsp_ready;
        w       = ref_winner(pv, m_rr);
        exp_rdy = (w >= 0 && can) ? (4'b0001 << w) : 4'b0000;
        chk("rnd_req_ready", req_ready, exp_rdy);
        chk("rnd_rsp_valid", rsp_valid, m_vld);
        if (m_vld) begin
          chk("rnd_rsp_id", rsp_id, m_id);
          chk("rnd_rsp_out1", rsp_out1, m_out1);
          chk("rnd_rsp_xor", rsp_xor, m_xor);
        end
        if (w >= 0 && can) begin
          m_vld  = 1'b1;
          m_id   = w;
          m_out1 = ref_out1(dv, w);
          m_xor  = ref_xor(dv, w);
          m_rr   = (w + 1) % 4;
          pv[w]  = 1'b0;
        end else if (rsp_ready) begin
          m_vld = 1'b0;
        end
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
